// File: rtl/oam_dma.sv
// OAM DMA engine behind register 0xFF46.
// A CPU write to 0xFF46 copies OAM_BYTES bytes from {src,8'h00} into sprite OAM.
// Source bytes are read over the MMU read path. OAM is written through a
// dedicated single-cycle write strobe.
// Optional feature macro: OAM_DMA_BUS_BLOCK_EN. When it is defined, the block
// raises oCpuBlock for CPU accesses outside HRAM while a transfer is running.
// Parameter limits: CYCLES_PER_BYTE >= 2, CYCLES_PER_BYTE >= READ_LATENCY + 1,
// and 1 <= OAM_BYTES <= 256.
module oam_dma #(
    parameter int OAM_BYTES       = 160,
    parameter int CYCLES_PER_BYTE = 4,
    parameter int READ_LATENCY    = 1,
    parameter int START_DELAY     = 1
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iCpuWe,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    output logic [7:0]  oDmaReg,
    output logic [15:0] oDmaReadAddr,
    input  logic [7:0]  iDmaReadData,
    output logic        oOamWe,
    output logic [7:0]  oOamAddr,
    output logic [7:0]  oOamData,
    output logic        oDmaActive,
    output logic        oDmaDone,
    output logic        oCpuBlock
);

    // The slot counter measures both the arm delay and the per-byte slot.
    localparam int SLOT_SPAN = (CYCLES_PER_BYTE > START_DELAY) ? CYCLES_PER_BYTE : START_DELAY;
    localparam int SLOT_W    = (SLOT_SPAN > 2) ? $clog2(SLOT_SPAN) : 1;

    localparam logic [SLOT_W-1:0] SLOT_READ  = SLOT_W'(READ_LATENCY);
    localparam logic [SLOT_W-1:0] SLOT_PRE   = SLOT_W'(CYCLES_PER_BYTE - 2);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(CYCLES_PER_BYTE - 1);
    localparam logic [SLOT_W-1:0] ARM_LAST   = SLOT_W'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [7:0]        LAST_INDEX = 8'(OAM_BYTES - 1);

    // When the read data arrives in the write cycle itself, it cannot be
    // registered ahead of the write, so it is passed straight through.
    localparam bit DATA_BYPASS = (READ_LATENCY == CYCLES_PER_BYTE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        XFER
    } state_t;

    state_t            state;
    logic [SLOT_W-1:0] slot;
    logic [7:0]        index;
    logic [7:0]        src;
    logic [7:0]        data_q;
    logic [7:0]        dma_reg;
    logic              oam_we_q;
    logic [7:0]        oam_addr_q;
    logic [7:0]        oam_data_q;
    logic              active_q;
    logic              done_q;
    logic              trigger;

    assign trigger = iCpuWe && (iCpuAddr == 16'hFF46);

    // Sequencer: trigger handling, arm delay, per-byte read/capture/write slots.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state      <= IDLE;
            slot       <= '0;
            index      <= 8'h00;
            src        <= 8'h00;
            data_q     <= 8'h00;
            dma_reg    <= 8'hFF;
            oam_we_q   <= 1'b0;
            oam_addr_q <= 8'h00;
            oam_data_q <= 8'h00;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // Strobes default low so each one lasts exactly one cycle.
            oam_we_q <= 1'b0;
            done_q   <= 1'b0;

            if (trigger) begin
                // A trigger restarts from byte 0. A write already on the
                // port this cycle still completes, and no done pulse is given.
                dma_reg  <= iCpuData;
                src      <= (iCpuData > 8'hDF) ? (iCpuData - 8'h20) : iCpuData;
                index    <= 8'h00;
                slot     <= '0;
                active_q <= 1'b1;
                state    <= (START_DELAY == 0) ? XFER : ARM;
            end else begin
                case (state)
                    IDLE: begin
                        slot <= '0;
                    end
                    ARM: begin
                        if (slot == ARM_LAST) begin
                            slot  <= '0;
                            state <= XFER;
                        end else begin
                            slot <= slot + 1'b1;
                        end
                    end
                    XFER: begin
                        if (slot == SLOT_READ) begin
                            data_q <= iDmaReadData;
                        end
                        // Set up the write one edge early so the strobe is
                        // high during the last slot cycle.
                        if (slot == SLOT_PRE) begin
                            oam_we_q   <= 1'b1;
                            oam_addr_q <= index;
                            oam_data_q <= (slot == SLOT_READ) ? iDmaReadData : data_q;
                        end
                        if (slot == SLOT_LAST) begin
                            slot <= '0;
                            if (DATA_BYPASS) begin
                                oam_data_q <= iDmaReadData;
                            end
                            if (index == LAST_INDEX) begin
                                state    <= IDLE;
                                active_q <= 1'b0;
                                done_q   <= 1'b1;
                            end else begin
                                index <= index + 8'h01;
                            end
                        end else begin
                            slot <= slot + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Because index stays below 256, {src,8'h00}+index is a plain concatenation.
    assign oDmaReadAddr = {src, index};
    assign oDmaReg      = dma_reg;
    assign oOamWe       = oam_we_q;
    assign oOamAddr     = oam_addr_q;
    assign oOamData     = (DATA_BYPASS && oam_we_q) ? iDmaReadData : oam_data_q;
    assign oDmaActive   = active_q;
    assign oDmaDone     = done_q;

`ifdef OAM_DMA_BUS_BLOCK_EN
    // CPU keeps HRAM (FF80-FFFE) during a transfer. Every other access is blocked.
    assign oCpuBlock = active_q && !((iCpuAddr >= 16'hFF80) && (iCpuAddr <= 16'hFFFE));
`else
    assign oCpuBlock = 1'b0;
`endif

endmodule
